// File: rtl/adsr_poly_if.sv
// adsr_poly_if: control and level bundle for the adsr_poly engine.
// The trig vector exists only when ADSR_POLY_RETRIGGER_EN is defined.
interface adsr_poly_if #(
  parameter int CHANNELS = 4,
  parameter int WIDTH = 8
);
  logic                      low_clk;
  logic [CHANNELS-1:0]       gate;
  logic [4*CHANNELS-1:0]     a;
  logic [4*CHANNELS-1:0]     d;
  logic [4*CHANNELS-1:0]     s;
  logic [4*CHANNELS-1:0]     r;
  logic [CHANNELS*WIDTH-1:0] signal_out;
  logic                      busy;
  logic                      overrun;
`ifdef ADSR_POLY_RETRIGGER_EN
  logic [CHANNELS-1:0]       trig;

  modport master (
    output low_clk, gate, a, d, s, r, trig,
    input  signal_out, busy, overrun
  );
  modport slave (
    input  low_clk, gate, a, d, s, r, trig,
    output signal_out, busy, overrun
  );
`else
  modport master (
    output low_clk, gate, a, d, s, r,
    input  signal_out, busy, overrun
  );
  modport slave (
    input  low_clk, gate, a, d, s, r,
    output signal_out, busy, overrun
  );
`endif
endinterface

// File: rtl/adsr_poly.sv
// adsr_poly: one shared ADSR engine swept across CHANNELS voices per tick.
// Define ADSR_POLY_RETRIGGER_EN to add per-channel trig retrigger inputs.
module adsr_poly #(
  parameter int CHANNELS = 4,
  parameter int WIDTH = 8,
  parameter int ACCUMULATOR_BITS = 26
) (
  input  logic       clk,
  input  logic       reset,
  adsr_poly_if.slave bus
);
  localparam int AB = ACCUMULATOR_BITS;
  localparam int PW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [AB:0] INC0 = (AB+1)'(1) << (AB - 4);
  localparam logic [AB-1:0] MAXV = '1;
  localparam logic [WIDTH+3:0] FS = (WIDTH+4)'((1 << WIDTH) - 1);
  localparam logic [PW-1:0] LAST = PW'(CHANNELS - 1);

  typedef enum logic [2:0] {
    OFF, ATTACK, DECAY, SUSTAIN, RELEASE
  } st_t;

  logic [AB-1:0] acc_q [CHANNELS];
  st_t           st_q  [CHANNELS];
  logic [PW-1:0] ptr_q;
  logic          busy_q;
  logic          ovr_q;

  logic [AB-1:0] acc_d;
  st_t           st_d;

  logic [CHANNELS-1:0] svc;
  logic          g;
  logic [3:0]    na, nd, ns, nr;
  logic [AB-1:0] acc;
  st_t           st;

  // operand mux for the channel under service
  always_comb begin
    svc = '0;
    g = 1'b0;
    na = '0;
    nd = '0;
    ns = '0;
    nr = '0;
    acc = '0;
    st = OFF;
    for (int k = 0; k < CHANNELS; k++) begin
      if (ptr_q == PW'(k)) begin
        svc[k] = busy_q;
        g = bus.gate[k];
        na = bus.a[4*k +: 4];
        nd = bus.d[4*k +: 4];
        ns = bus.s[4*k +: 4];
        nr = bus.r[4*k +: 4];
        acc = acc_q[k];
        st = st_q[k];
      end
    end
  end

  logic [WIDTH+3:0] prod;
  logic [WIDTH-1:0] sl;
  logic [AB-1:0]    sa;
  logic [AB:0]      sum, dsub, rsub;

  assign prod = {{WIDTH{1'b0}}, ns} * FS;
  assign sl   = WIDTH'(prod / (WIDTH+4)'(15));
  assign sa   = {sl, {(AB-WIDTH){1'b0}}};
  assign sum  = {1'b0, acc} + (INC0 >> na);
  assign dsub = {1'b0, acc} - (INC0 >> nd);
  assign rsub = {1'b0, acc} - (INC0 >> nr);

  logic [AB-1:0] att_acc, dec_acc, rel_acc;
  st_t           att_st, dec_st, rel_st;

  // one step of each phase, with saturation via the extra MSB
  always_comb begin
    att_acc = sum[AB-1:0];
    att_st  = ATTACK;
    if (sum >= {1'b0, MAXV}) begin
      att_acc = MAXV;
      att_st  = DECAY;
    end
    dec_acc = dsub[AB-1:0];
    dec_st  = DECAY;
    if (dsub[AB] || dsub[AB-1:0] <= sa) begin
      dec_acc = sa;
      dec_st  = SUSTAIN;
    end
    rel_acc = rsub[AB-1:0];
    rel_st  = RELEASE;
    if (rsub[AB] || rsub[AB-1:0] == '0) begin
      rel_acc = '0;
      rel_st  = OFF;
    end
  end

`ifdef ADSR_POLY_RETRIGGER_EN
  logic [CHANNELS-1:0] pend_q;
  logic                pend;

  assign pend = |(pend_q & svc);

  // a trig in the channel's own service cycle survives the clear
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q <= '0;
    end else begin
      pend_q <= (pend_q & ~svc) | bus.trig;
    end
  end
`endif

  always_comb begin
    acc_d = acc;
    st_d  = st;
    unique case (st)
      OFF: begin
        if (g) begin
          acc_d = att_acc;
          st_d  = att_st;
        end else begin
          acc_d = '0;
        end
      end
      ATTACK: begin
        if (!g) begin
          st_d = RELEASE;
        end else begin
          acc_d = att_acc;
          st_d  = att_st;
        end
      end
      DECAY: begin
        if (!g) begin
          st_d = RELEASE;
        end else begin
          acc_d = dec_acc;
          st_d  = dec_st;
        end
      end
      SUSTAIN: begin
        if (!g) begin
          acc_d = rel_acc;
          st_d  = rel_st;
        end else begin
          acc_d = sa;
        end
      end
      RELEASE: begin
        if (g) begin
          acc_d = att_acc;
          st_d  = att_st;
        end else begin
          acc_d = rel_acc;
          st_d  = rel_st;
        end
      end
      default: begin
        acc_d = '0;
        st_d  = OFF;
      end
    endcase
`ifdef ADSR_POLY_RETRIGGER_EN
    if (pend && g) begin
      acc_d = att_acc;
      st_d  = att_st;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q <= 1'b0;
      ovr_q  <= 1'b0;
      ptr_q  <= '0;
      for (int k = 0; k < CHANNELS; k++) begin
        acc_q[k] <= '0;
        st_q[k]  <= OFF;
      end
    end else begin
      if (bus.low_clk) begin
        if (busy_q) begin
          ovr_q <= 1'b1;
        end else begin
          busy_q <= 1'b1;
          ptr_q  <= '0;
        end
      end
      if (busy_q) begin
        for (int k = 0; k < CHANNELS; k++) begin
          if (svc[k]) begin
            acc_q[k] <= acc_d;
            st_q[k]  <= st_d;
          end
        end
        if (ptr_q == LAST) begin
          busy_q <= 1'b0;
          ptr_q  <= '0;
        end else begin
          ptr_q <= ptr_q + PW'(1);
        end
      end
    end
  end

  for (genvar k = 0; k < CHANNELS; k++) begin : g_out
    assign bus.signal_out[WIDTH*k +: WIDTH] =
      acc_q[k][AB-1 -: WIDTH];
  end

  assign bus.busy    = busy_q;
  assign bus.overrun = ovr_q;
endmodule

// File: doc/adsr_poly.md
ADSR_POLY -- requirements
Module: adsr_poly

Interface
REQ-001 Parameter CHANNELS, default 4: number of independent envelope channels; legal range 1 to 64.
REQ-002 Parameter WIDTH, default 8: envelope output bits per channel; legal range 4 to 16.
REQ-003 Parameter ACCUMULATOR_BITS, default 26: per-channel accumulator width; SHALL be at least WIDTH+4 and at least 20.
REQ-004 clk  in  1  single clock; all logic on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 low_clk  in  1  envelope tick enable, one clk wide, sampled on clk.
REQ-007 gate  in  CHANNELS  per-channel note gate, level-sensitive.
REQ-008 a, d, s, r  in  4*CHANNELS each  packed per-channel 4-bit settings; channel k uses bits [4k+3:4k].
REQ-009 signal_out  out  CHANNELS*WIDTH  packed envelope levels; channel k uses bits [WIDTH*k+WIDTH-1:WIDTH*k].
REQ-010 busy  out  1  high while a service sweep is in progress.
REQ-011 overrun  out  1  sticky flag: a tick arrived while busy was high.

Function
REQ-012 One shared time-multiplexed engine SHALL service the channels; per-channel accumulator and state SHALL be held in register arrays.
REQ-013 Tick at cycle T with busy low: channel k is serviced in cycle T+1+k; busy is high in cycles T+1 through T+CHANNELS; busy is low in T and T+CHANNELS+1.
REQ-014 Tick while busy is high: tick ignored, overrun set to 1, sweep continues unchanged.
REQ-015 gate, a, d, s and r for channel k SHALL be sampled in channel k's service cycle only.
REQ-016 Rate increment inc(n) = 2^(ACCUMULATOR_BITS-4-n) for setting n = 0..15.
REQ-017 Sustain level SL = floor(s*(2^WIDTH-1)/15); sustain accumulator SA = SL << (ACCUMULATOR_BITS-WIDTH).
REQ-018 States per channel: OFF, ATTACK, DECAY, SUSTAIN, RELEASE.
REQ-019 OFF: gate=1 -> ATTACK; otherwise the accumulator SHALL remain 0.
REQ-020 ATTACK: gate=0 -> RELEASE with no add; otherwise acc += inc(a); if sum >= 2^ACCUMULATOR_BITS-1, acc = 2^ACCUMULATOR_BITS-1 and -> DECAY.
REQ-021 DECAY: gate=0 -> RELEASE with no subtract; otherwise acc -= inc(d); if result <= SA or it underflows, acc = SA and -> SUSTAIN.
REQ-022 SUSTAIN: gate=0 -> RELEASE; otherwise acc = SA, tracking live changes to s.
REQ-023 RELEASE: gate=1 -> ATTACK from the current accumulator; otherwise acc -= inc(r); if result <= 0 or it underflows, acc = 0 and -> OFF.
REQ-024 Arithmetic SHALL use one extra carry/borrow bit; the accumulator SHALL never wrap around.
REQ-025 signal_out slice k SHALL equal acc_k[ACCUMULATOR_BITS-1 -: WIDTH], registered at the end of channel k's service cycle; the other slices hold their values.
REQ-026 Levels SHALL change only on service cycles; between sweeps all outputs hold.

Reset
REQ-027 On reset=1 at a clk edge, all of the following SHALL take effect on that edge, including mid-sweep:
- all accumulators = 0
- all states = OFF
- signal_out = 0, busy = 0, overrun = 0
- sweep pointer = 0
- pending triggers cleared
REQ-028 A tick coincident with reset SHALL be ignored.

Configuration
REQ-029 Macro ADSR_POLY_RETRIGGER_EN defined: the module SHALL have an extra input port trig (CHANNELS bits, single-cycle pulses).
REQ-030 With ADSR_POLY_RETRIGGER_EN defined: a trig pulse on channel k in any cycle sets a pending flag for k. At k's next service, if the pending flag is set and gate=1, the channel SHALL enter ATTACK from its current accumulator. In that service the attack add is applied, with priority over the REQ-019..REQ-023 transitions. The pending flag SHALL be cleared at every service of k.
REQ-031 With ADSR_POLY_RETRIGGER_EN defined: a trig pulse in channel k's own service cycle SHALL stay pending until the next sweep.
REQ-032 Macro ADSR_POLY_RETRIGGER_EN undefined: the trig port and pending flags SHALL be absent, and behaviour is gate-only.

Verification (CHANNELS=4, WIDTH=8, ACCUMULATOR_BITS=26)
REQ-033 Reset, then 3 ticks with all gates 0 -> all signal_out = 0; busy high for 4 cycles after each tick; overrun = 0.
REQ-034 Channel 0: a=0, d=0, s=8, gate=1 -> level 255 with state DECAY after tick 16; SUSTAIN with level 136 after tick 24; other slices remain 0.
REQ-035 Channel 0 in SUSTAIN at 136, r=0, gate->0 -> RELEASE; level 0 and OFF after 9 ticks.
REQ-036 Gate 0 during ATTACK at level 127, then gate 1 again before reaching 0 -> attack resumes from the current level, with no drop to 0.
REQ-037 Second tick 2 cycles after the first -> overrun=1, sweep completes normally, overrun stays 1 until reset.
REQ-038 With ADSR_POLY_RETRIGGER_EN: channel 1 in SUSTAIN at 136, gate held 1, trig pulse -> ATTACK; level 136+16=152 after the next sweep.
